// File: rtl/reg_scoreboard_pkg.sv
// Shared register definitions for the issue scoreboard: fixed register indices
// and the per-entry control bundle passed to each in-flight counter.
package reg_scoreboard_pkg;

   localparam int REG_ID_W = 5;
   localparam int ZERO_IDX = 0;
   localparam int RA_IDX   = 31;
   localparam int HILO_IDX = 32;

   typedef struct packed {
      logic inc;
      logic dec;
   } entry_ctl_t;

   // True when an enabled general-register id names entry idx; $zero never matches.
   function automatic logic id_hit(input logic en,
                                   input logic [REG_ID_W-1:0] id,
                                   input int idx);
      return en && (idx != ZERO_IDX) && (idx < HILO_IDX) && (int'(id) == idx);
   endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down in-flight write counter for one scoreboard entry.
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero_dec_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // A paired inc/dec is a net no-op, so only a lone retire on an empty entry is an error.
   assign zero_dec_err = dec & ~inc & (count == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && !dec && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writes per register and hi/lo,
// stalls decode on RAW hazards or full destination counters, flags stray retires.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [REG_ID_W-1:0] reg_rs_id,
   input  logic [REG_ID_W-1:0] reg_rt_id,
   input  logic                reads_rs,
   input  logic                reads_rt,
   input  logic                reads_hilo,
   input  logic                issue_valid,
   input  logic                issue_reg_write,
   input  logic [REG_ID_W-1:0] issue_write_id,
   input  logic                issue_ra_write,
   input  logic                issue_hilo_write,
   input  logic                control_reg_write,
   input  logic [REG_ID_W-1:0] control_write_id,
   input  logic                ra_write,
   input  logic                HasDivW,
   output logic                stall_D,
   output logic                issue_accept,
   output logic                sb_error
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [HILO_IDX:0] busy_vec;
   logic [HILO_IDX:0] full_vec;
   logic [HILO_IDX:0] dest_vec;
   logic [HILO_IDX:0] err_vec;
   logic              src_hazard;
   logic              dest_full;

   assign busy_vec[ZERO_IDX] = 1'b0;
   assign full_vec[ZERO_IDX] = 1'b0;
   assign dest_vec[ZERO_IDX] = 1'b0;
   assign err_vec[ZERO_IDX]  = 1'b0;

   // A count of 1 retiring this cycle is readable: the register file writes at negedge.
   for (genvar i = 1; i <= HILO_IDX; i++) begin : g_entry
      if ((i < NUM_REGS) || (i == HILO_IDX)) begin : g_tracked
         entry_ctl_t       ctl;
         logic [CNT_W-1:0] count;

         if (i == HILO_IDX) begin : g_hilo
            assign ctl.inc = issue_hilo_write;
            assign ctl.dec = HasDivW;
         end else begin : g_gpr
            assign ctl.inc = id_hit(issue_reg_write, issue_write_id, i)
                           | ((i == RA_IDX) && issue_ra_write);
            assign ctl.dec = id_hit(control_reg_write, control_write_id, i)
                           | ((i == RA_IDX) && ra_write);
         end

         sb_counter #(.CNT_W(CNT_W)) u_counter (
            .clock        (clock),
            .reset        (reset),
            .inc          (issue_accept & ctl.inc),
            .dec          (ctl.dec),
            .count        (count),
            .zero_dec_err (err_vec[i])
         );

         assign busy_vec[i] = (count != '0) && !((count == CNT_W'(1)) && ctl.dec);
         assign full_vec[i] = (count == CNT_MAX) && !ctl.dec;
         assign dest_vec[i] = ctl.inc;
      end else begin : g_untracked
         assign busy_vec[i] = 1'b0;
         assign full_vec[i] = 1'b0;
         assign dest_vec[i] = 1'b0;
         assign err_vec[i]  = 1'b0;
      end
   end

   assign src_hazard = (reads_rs   && busy_vec[{1'b0, reg_rs_id}])
                     | (reads_rt   && busy_vec[{1'b0, reg_rt_id}])
                     | (reads_hilo && busy_vec[HILO_IDX]);
   assign dest_full    = |(dest_vec & full_vec);
   assign stall_D      = issue_valid & (src_hazard | dest_full);
   assign issue_accept = issue_valid & ~stall_D;

   // Sticky until reset so a single stray retire is never lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         sb_error <= 1'b0;
      end else if (|err_vec) begin
         sb_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hand-computed stall/accept/error expectations
// across hazard, saturation, $zero, hi/lo, $ra and reset scenarios.
module tb_reg_scoreboard;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] reg_rs_id;
   logic [4:0] reg_rt_id;
   logic       reads_rs;
   logic       reads_rt;
   logic       reads_hilo;
   logic       issue_valid;
   logic       issue_reg_write;
   logic [4:0] issue_write_id;
   logic       issue_ra_write;
   logic       issue_hilo_write;
   logic       control_reg_write;
   logic [4:0] control_write_id;
   logic       ra_write;
   logic       HasDivW;
   logic       stall_D;
   logic       issue_accept;
   logic       sb_error;

   int vectors     = 0;
   int miscompares = 0;

   reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
      .clock             (clock),
      .reset             (reset),
      .reg_rs_id         (reg_rs_id),
      .reg_rt_id         (reg_rt_id),
      .reads_rs          (reads_rs),
      .reads_rt          (reads_rt),
      .reads_hilo        (reads_hilo),
      .issue_valid       (issue_valid),
      .issue_reg_write   (issue_reg_write),
      .issue_write_id    (issue_write_id),
      .issue_ra_write    (issue_ra_write),
      .issue_hilo_write  (issue_hilo_write),
      .control_reg_write (control_reg_write),
      .control_write_id  (control_write_id),
      .ra_write          (ra_write),
      .HasDivW           (HasDivW),
      .stall_D           (stall_D),
      .issue_accept      (issue_accept),
      .sb_error          (sb_error)
   );

   always #5 clock = ~clock;

   task automatic apply_idle();
      reg_rs_id         = '0;
      reg_rt_id         = '0;
      reads_rs          = 1'b0;
      reads_rt          = 1'b0;
      reads_hilo        = 1'b0;
      issue_valid       = 1'b0;
      issue_reg_write   = 1'b0;
      issue_write_id    = '0;
      issue_ra_write    = 1'b0;
      issue_hilo_write  = 1'b0;
      control_reg_write = 1'b0;
      control_write_id  = '0;
      ra_write          = 1'b0;
      HasDivW           = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
      end
   endtask

   task automatic issue_write(input logic [4:0] id);
      apply_idle();
      issue_valid     = 1'b1;
      issue_reg_write = 1'b1;
      issue_write_id  = id;
   endtask

   task automatic retire_write(input logic [4:0] id);
      apply_idle();
      control_reg_write = 1'b1;
      control_write_id  = id;
   endtask

   initial begin
      apply_idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check_output("reset_stall", stall_D, 1'b0);
      check_output("reset_accept", issue_accept, 1'b0);
      check_output("reset_err", sb_error, 1'b0);

      // $8 written, then read before and with its retire
      issue_write(5'd8);
      #1 check_output("w8_accept", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd8;
      #1 check_output("r8_stall", stall_D, 1'b1);
      check_output("r8_accept", issue_accept, 1'b0);
      control_reg_write = 1'b1;
      control_write_id  = 5'd8;
      #1 check_output("r8_bypass_stall", stall_D, 1'b0);
      check_output("r8_bypass_accept", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rt    = 1'b1;
      reg_rt_id   = 5'd8;
      #1 check_output("r8_clear", stall_D, 1'b0);

      // $5 saturates at 3 in flight
      for (int k = 0; k < 3; k++) begin
         issue_write(5'd5);
         #1 check_output("w5_accept", issue_accept, 1'b1);
         tick();
      end
      issue_write(5'd5);
      #1 check_output("w5_full_stall", stall_D, 1'b1);
      check_output("w5_full_accept", issue_accept, 1'b0);
      control_reg_write = 1'b1;
      control_write_id  = 5'd5;
      #1 check_output("w5_full_retire_accept", issue_accept, 1'b1);
      tick();
      issue_write(5'd5);
      #1 check_output("w5_still3_stall", stall_D, 1'b1);
      apply_idle();
      issue_valid = 1'b1;
      reads_rt    = 1'b1;
      reg_rt_id   = 5'd5;
      #1 check_output("r5_rt_stall", stall_D, 1'b1);
      for (int k = 0; k < 3; k++) begin
         retire_write(5'd5);
         tick();
      end
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd5;
      #1 check_output("r5_drained", stall_D, 1'b0);
      check_output("r5_no_err", sb_error, 1'b0);

      // $zero is never tracked
      issue_write(5'd0);
      #1 check_output("w0_accept", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reads_rt    = 1'b1;
      #1 check_output("r0_stall", stall_D, 1'b0);
      retire_write(5'd0);
      tick();
      check_output("retire0_no_err", sb_error, 1'b0);

      // hi/lo pending until HasDivW
      apply_idle();
      issue_valid      = 1'b1;
      issue_hilo_write = 1'b1;
      #1 check_output("hilo_issue", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_hilo  = 1'b1;
      #1 check_output("hilo_stall", stall_D, 1'b1);
      issue_valid = 1'b0;
      #1 check_output("hilo_novalid", stall_D, 1'b0);
      tick();
      issue_valid = 1'b1;
      #1 check_output("hilo_still_stall", stall_D, 1'b1);
      HasDivW = 1'b1;
      #1 check_output("hilo_retire_accept", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_hilo  = 1'b1;
      #1 check_output("hilo_clear", stall_D, 1'b0);

      // jal counts $ra once; paired retire also counts once
      apply_idle();
      issue_valid     = 1'b1;
      issue_ra_write  = 1'b1;
      issue_reg_write = 1'b1;
      issue_write_id  = 5'd31;
      #1 check_output("jal_accept", issue_accept, 1'b1);
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd31;
      #1 check_output("ra_busy", stall_D, 1'b1);
      apply_idle();
      ra_write = 1'b1;
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd31;
      #1 check_output("ra_count_was_1", stall_D, 1'b0);
      check_output("ra_no_err", sb_error, 1'b0);
      for (int k = 0; k < 2; k++) begin
         apply_idle();
         issue_valid    = 1'b1;
         issue_ra_write = 1'b1;
         tick();
      end
      retire_write(5'd31);
      ra_write = 1'b1;
      tick();
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd31;
      #1 check_output("ra_paired_retire", stall_D, 1'b1);
      apply_idle();
      ra_write = 1'b1;
      tick();
      check_output("ra_drain_no_err", sb_error, 1'b0);

      // reset discards pending writes; a later retire is stray
      issue_write(5'd9);
      tick();
      issue_write(5'd10);
      tick();
      apply_idle();
      control_reg_write = 1'b1;
      control_write_id  = 5'd9;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      apply_idle();
      issue_valid = 1'b1;
      reads_rs    = 1'b1;
      reg_rs_id   = 5'd9;
      reads_rt    = 1'b1;
      reg_rt_id   = 5'd10;
      #1 check_output("post_reset_stall", stall_D, 1'b0);
      check_output("post_reset_err", sb_error, 1'b0);
      retire_write(5'd9);
      tick();
      check_output("stray_retire_err", sb_error, 1'b1);
      apply_idle();
      tick();
      tick();
      check_output("err_sticky", sb_error, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1 check_output("err_cleared", sb_error, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
